multicycle_ctrl: RTL and testbench
==================================

Name: multicycle_ctrl

Overview:
- Main control FSM for the multi-cycle RV32I datapath.
- Sits directly upstream of ALU_op: produces the 2-bit alu_op class that ALU_op combines with funct3/funct7[5] to select the ALU function.
- Also sequences PC, IR, register-file and memory enables from the IR opcode, with a ready handshake to unified instruction/data memory.

Parameters:
- RETIRE_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous active-high reset
- opcode  in  7  IR[6:0]; valid from DECODE onward
- zero_taken  in  1  branch comparator result (funct3-resolved) from the datapath
- mem_ready  in  1  memory completed the current read/write this cycle
- alu_op  out  2  00 add, 01 branch compare, 10 use funct (to ALU_op)
- alu_src_a  out  2  00 old_pc, 01 rs1, 10 pc
- alu_src_b  out  2  00 rs2, 01 const 4, 10 imm
- pc_write  out  1  unconditional PC load
- pc_write_cond  out  1  PC load if zero_taken
- pc_src  out  1  0 ALU result, 1 ALUOut register
- ir_write  out  1  latch IR and old_pc
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request
- iord  out  1  0 address = pc, 1 address = ALUOut
- reg_write  out  1  register-file write
- wb_sel  out  2  00 ALUOut, 01 MDR, 10 pc
- illegal  out  1  one-cycle pulse on an unsupported opcode
- retired  out  RETIRE_W  count of completed instructions

Behaviour:
- Reset (async): state IDLE, retired = 0. During rst and in IDLE every output is 0.
- Outputs are Moore: combinational decode of the state only. Exceptions:
  - pc_write and ir_write in FETCH are ANDed with mem_ready.
  - illegal is asserted in DECODE when the opcode is unsupported.
- IDLE: unconditionally goes to FETCH after one cycle.
- FETCH:
  - Asserts mem_read, iord=0, alu_src_a=10, alu_src_b=01, alu_op=00, pc_src=0.
  - Holds until mem_ready=1; on that cycle pc_write=1 and ir_write=1, then goes to DECODE.
- DECODE:
  - alu_src_a=00, alu_src_b=10, alu_op=00 (ALUOut = old_pc+imm, the branch/jump target).
  - Next state by opcode:
    - 0110011 -> EXEC_R
    - 0010011 -> EXEC_I
    - 0000011 or 0100011 -> ADDR
    - 1100011 -> BRANCH
    - 1101111 -> JAL
    - any other -> FETCH, with illegal=1 for this cycle only and retired unchanged.
- EXEC_R: alu_src_a=01, alu_src_b=00, alu_op=10 -> WB_ALU.
- EXEC_I: alu_src_a=01, alu_src_b=10, alu_op=10 -> WB_ALU.
- ADDR: alu_src_a=01, alu_src_b=10, alu_op=00 -> MEM_RD if opcode=0000011, else MEM_WR.
- MEM_RD: mem_read=1, iord=1; holds until mem_ready -> WB_MEM.
- MEM_WR: mem_write=1, iord=1; holds until mem_ready -> FETCH; retired increments.
- WB_ALU: reg_write=1, wb_sel=00 -> FETCH; retired increments.
- WB_MEM: reg_write=1, wb_sel=01 -> FETCH; retired increments.
- BRANCH:
  - alu_src_a=01, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_src=1 -> FETCH.
  - retired increments whether or not the branch is taken.
- JAL: pc_write=1, pc_src=1, reg_write=1, wb_sel=10 (pc already old_pc+4) -> FETCH; retired increments.
- Handshake:
  - mem_read/mem_write stay high, with a stable address, until mem_ready is sampled 1.
  - mem_ready in any other state is ignored.
  - mem_ready already high on the first cycle of a memory state completes that state in one cycle.
- Never asserted together: mem_read and mem_write; pc_write and pc_write_cond.
- retired wraps modulo 2^RETIRE_W.
- Reset mid-instruction:
  - Immediately forces IDLE and all outputs 0, including any pending mem request.
  - The count of the in-flight instruction is not added.
- Cycles per instruction, with zero memory wait:
  - R/I: 4
  - load: 5
  - store: 4
  - branch: 3
  - JAL: 3

Test Plan:
- Reset, then release; opcode=0110011, mem_ready=1 constantly -> IDLE 1 cycle, then FETCH/DECODE/EXEC_R/WB_ALU; alu_op=10 in EXEC_R; reg_write=1 in cycle 4; retired=1.
- Load (0000011), mem_ready low for 3 cycles in MEM_RD -> mem_read=1 and iord=1 held for 4 cycles; WB_MEM asserts wb_sel=01 and reg_write; retired +1.
- Store (0100011) -> alu_op=00 in ADDR; mem_write=1 only in MEM_WR; reg_write never asserted; 4 cycles with zero wait.
- Branch (1100011) with zero_taken=1 and then zero_taken=0 -> pc_write_cond=1, pc_src=1, alu_op=01 in BRANCH both times; both increment retired.
- Opcode 1111111 -> illegal=1 for exactly one cycle in DECODE, back to FETCH, retired unchanged; JAL (1101111) -> wb_sel=10, pc_write=1, 3 cycles.
- Assert rst during MEM_RD with mem_read=1 -> mem_read=0 the same cycle (async); retired=0; after release, the first FETCH starts 2 cycles later (IDLE, then FETCH).

Source files
------------

// File: rtl/multicycle_ctrl.sv
// Main control FSM for the multi-cycle RV32I datapath: sequences PC/IR/regfile/memory
// enables from the IR opcode and produces the alu_op class consumed by ALU_op.
module multicycle_ctrl #(
   parameter int RETIRE_W = 32
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [6:0]          opcode,
   input  logic                zero_taken,
   input  logic                mem_ready,
   output logic [1:0]          alu_op,
   output logic [1:0]          alu_src_a,
   output logic [1:0]          alu_src_b,
   output logic                pc_write,
   output logic                pc_write_cond,
   output logic                pc_src,
   output logic                ir_write,
   output logic                mem_read,
   output logic                mem_write,
   output logic                iord,
   output logic                reg_write,
   output logic [1:0]          wb_sel,
   output logic                illegal,
   output logic [RETIRE_W-1:0] retired
);

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;

   typedef enum logic [3:0] {
      S_IDLE, S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_ADDR,
      S_MEM_RD, S_MEM_WR, S_WB_ALU, S_WB_MEM, S_BRANCH, S_JAL
   } state_t;

   state_t                r_state;
   state_t                w_next;
   logic                  w_retire;
   logic [RETIRE_W-1:0]   r_retired;

   // The branch decision is applied by the datapath's PC-enable gate
   // (pc_write | pc_write_cond & zero_taken); the FSM never needs it.
   logic w_unused;
   assign w_unused = zero_taken;

   // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_retired <= '0;
      end else begin
         r_state <= w_next;
         if (w_retire) r_retired <= r_retired + RETIRE_W'(1);
      end
   end

   assign retired = r_retired;

   always_comb begin
      // NOTE: every output gets a default first so no path through the case infers a latch.
      w_next        = r_state;
      w_retire      = 1'b0;
      alu_op        = 2'b00;
      alu_src_a     = 2'b00;
      alu_src_b     = 2'b00;
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      pc_src        = 1'b0;
      ir_write      = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      iord          = 1'b0;
      reg_write     = 1'b0;
      wb_sel        = 2'b00;
      illegal       = 1'b0;

      case (r_state)
         S_IDLE: w_next = S_FETCH;
         S_FETCH: begin
            mem_read  = 1'b1;
            alu_src_a = 2'b10;
            alu_src_b = 2'b01;
            pc_write  = mem_ready;
            ir_write  = mem_ready;
            if (mem_ready) w_next = S_DECODE;
         end
         S_DECODE: begin
            // ALUOut captures old_pc + imm here for branches and JAL.
            alu_src_b = 2'b10;
            case (opcode)
               OP_R:               w_next = S_EXEC_R;
               OP_I:               w_next = S_EXEC_I;
               OP_LOAD, OP_STORE:  w_next = S_ADDR;
               OP_BRANCH:          w_next = S_BRANCH;
               OP_JAL:             w_next = S_JAL;
               default: begin
                  illegal = 1'b1;
                  w_next  = S_FETCH;
               end
            endcase
         end
         S_EXEC_R: begin
            alu_src_a = 2'b01;
            alu_op    = 2'b10;
            w_next    = S_WB_ALU;
         end
         S_EXEC_I: begin
            alu_src_a = 2'b01;
            alu_src_b = 2'b10;
            alu_op    = 2'b10;
            w_next    = S_WB_ALU;
         end
         S_ADDR: begin
            alu_src_a = 2'b01;
            alu_src_b = 2'b10;
            w_next    = (opcode == OP_LOAD) ? S_MEM_RD : S_MEM_WR;
         end
         S_MEM_RD: begin
            mem_read = 1'b1;
            iord     = 1'b1;
            if (mem_ready) w_next = S_WB_MEM;
         end
         S_MEM_WR: begin
            mem_write = 1'b1;
            iord      = 1'b1;
            if (mem_ready) begin
               w_next   = S_FETCH;
               w_retire = 1'b1;
            end
         end
         S_WB_ALU: begin
            reg_write = 1'b1;
            w_next    = S_FETCH;
            w_retire  = 1'b1;
         end
         S_WB_MEM: begin
            reg_write = 1'b1;
            wb_sel    = 2'b01;
            w_next    = S_FETCH;
            w_retire  = 1'b1;
         end
         S_BRANCH: begin
            alu_src_a     = 2'b01;
            alu_op        = 2'b01;
            pc_write_cond = 1'b1;
            pc_src        = 1'b1;
            w_next        = S_FETCH;
            w_retire      = 1'b1;
         end
         S_JAL: begin
            // The PC already holds old_pc + 4, which is the link value.
            pc_write  = 1'b1;
            pc_src    = 1'b1;
            reg_write = 1'b1;
            wb_sel    = 2'b10;
            w_next    = S_FETCH;
            w_retire  = 1'b1;
         end
         default: w_next = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: cycle-exact vector table, reset corner
// sequence, then random instructions checked against per-instruction totals.
module tb_multicycle_ctrl;

   localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LD = 7'b0000011;
   localparam logic [6:0] OP_ST = 7'b0100011, OP_BR = 7'b1100011, OP_JAL = 7'b1101111;

   // {alu_op, src_a, src_b, pc_write, pc_write_cond, pc_src, ir_write,
   //  mem_read, mem_write, iord, reg_write, wb_sel, illegal}
   localparam logic [16:0] O_ZERO  = 17'b00_00_00_0_0_0_0_0_0_0_0_00_0;
   localparam logic [16:0] O_FWAIT = 17'b00_10_01_0_0_0_0_1_0_0_0_00_0;
   localparam logic [16:0] O_FRDY  = 17'b00_10_01_1_0_0_1_1_0_0_0_00_0;
   localparam logic [16:0] O_DEC   = 17'b00_00_10_0_0_0_0_0_0_0_0_00_0;
   localparam logic [16:0] O_DECIL = 17'b00_00_10_0_0_0_0_0_0_0_0_00_1;
   localparam logic [16:0] O_EXR   = 17'b10_01_00_0_0_0_0_0_0_0_0_00_0;
   localparam logic [16:0] O_EXI   = 17'b10_01_10_0_0_0_0_0_0_0_0_00_0;
   localparam logic [16:0] O_ADDR  = 17'b00_01_10_0_0_0_0_0_0_0_0_00_0;
   localparam logic [16:0] O_MRD   = 17'b00_00_00_0_0_0_0_1_0_1_0_00_0;
   localparam logic [16:0] O_MWR   = 17'b00_00_00_0_0_0_0_0_1_1_0_00_0;
   localparam logic [16:0] O_WBA   = 17'b00_00_00_0_0_0_0_0_0_0_1_00_0;
   localparam logic [16:0] O_WBM   = 17'b00_00_00_0_0_0_0_0_0_0_1_01_0;
   localparam logic [16:0] O_BR    = 17'b01_01_00_0_1_1_0_0_0_0_0_00_0;
   localparam logic [16:0] O_JAL   = 17'b00_00_00_1_0_1_0_0_0_0_1_10_0;

   logic clk, rst, zero_taken, mem_ready;
   logic [6:0] opcode;
   logic [1:0] alu_op, alu_src_a, alu_src_b, wb_sel;
   logic pc_write, pc_write_cond, pc_src, ir_write, mem_read, mem_write, iord, reg_write, illegal;
   logic [31:0] retired;

   logic [1:0] n_alu_op, n_alu_src_a, n_alu_src_b, n_wb_sel;
   logic n_pc_write, n_pc_write_cond, n_pc_src, n_ir_write, n_mem_read, n_mem_write;
   logic n_iord, n_reg_write, n_illegal;
   logic [1:0] n_retired;

   logic [16:0] out_vec;
   assign out_vec = {alu_op, alu_src_a, alu_src_b, pc_write, pc_write_cond, pc_src, ir_write,
                     mem_read, mem_write, iord, reg_write, wb_sel, illegal};

   multicycle_ctrl #(.RETIRE_W(32)) u_dut (
      .clk(clk), .rst(rst), .opcode(opcode), .zero_taken(zero_taken), .mem_ready(mem_ready),
      .alu_op(alu_op), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .pc_write(pc_write),
      .pc_write_cond(pc_write_cond), .pc_src(pc_src), .ir_write(ir_write), .mem_read(mem_read),
      .mem_write(mem_write), .iord(iord), .reg_write(reg_write), .wb_sel(wb_sel),
      .illegal(illegal), .retired(retired)
   );

   // Narrow counter copy exercises the modulo-2^RETIRE_W wrap.
   multicycle_ctrl #(.RETIRE_W(2)) u_dut_w (
      .clk(clk), .rst(rst), .opcode(opcode), .zero_taken(zero_taken), .mem_ready(mem_ready),
      .alu_op(n_alu_op), .alu_src_a(n_alu_src_a), .alu_src_b(n_alu_src_b), .pc_write(n_pc_write),
      .pc_write_cond(n_pc_write_cond), .pc_src(n_pc_src), .ir_write(n_ir_write),
      .mem_read(n_mem_read), .mem_write(n_mem_write), .iord(n_iord), .reg_write(n_reg_write),
      .wb_sel(n_wb_sel), .illegal(n_illegal), .retired(n_retired)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        rst;
      logic [6:0]  op;
      logic        zt;
      logic        mr;
      logic [16:0] exp_out;
      logic [31:0] exp_ret;
   } vec_t;

   vec_t vt[$];
   int   n_checks = 0;
   int   n_err    = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic add(input logic r, input logic [6:0] op, input logic zt, input logic mr,
                      input logic [16:0] eo, input int er);
      vec_t v;
      v.rst = r; v.op = op; v.zt = zt; v.mr = mr; v.exp_out = eo; v.exp_ret = 32'(er);
      vt.push_back(v);
   endtask

   function automatic bit is_legal(input logic [6:0] o);
      return o inside {OP_R, OP_I, OP_LD, OP_ST, OP_BR, OP_JAL};
   endfunction

   int          k, wf, wm;
   int          c_rd, c_wr, c_rw, c_pcw, c_pcwc, c_irw, c_ill;
   int          e_rd, e_wr, e_rw, e_pcw, e_pcwc, e_irw, e_ill;
   logic [6:0]  op;
   logic [31:0] exp_ret;
   bit          rq[$];

   initial begin
      rst = 1'b1; opcode = OP_R; zero_taken = 1'b0; mem_ready = 1'b1;

      // One entry per clock cycle: R, I, load with 3 waits, store, branch taken / not
      // taken, illegal opcode, JAL, then a fetch stalled on memory.
      add(1, OP_R,   0, 1, O_ZERO, 0);   add(0, OP_R,   0, 1, O_ZERO, 0);
      add(0, OP_R,   0, 1, O_FRDY, 0);   add(0, OP_R,   0, 1, O_DEC,  0);
      add(0, OP_R,   0, 1, O_EXR,  0);   add(0, OP_R,   0, 1, O_WBA,  0);
      add(0, OP_I,   0, 0, O_FWAIT, 1);  add(0, OP_I,   0, 1, O_FRDY, 1);
      add(0, OP_I,   0, 1, O_DEC,  1);   add(0, OP_I,   0, 1, O_EXI,  1);
      add(0, OP_I,   0, 1, O_WBA,  1);   add(0, OP_LD,  0, 1, O_FRDY, 2);
      add(0, OP_LD,  0, 1, O_DEC,  2);   add(0, OP_LD,  0, 1, O_ADDR, 2);
      add(0, OP_LD,  0, 0, O_MRD,  2);   add(0, OP_LD,  0, 0, O_MRD,  2);
      add(0, OP_LD,  0, 0, O_MRD,  2);   add(0, OP_LD,  0, 1, O_MRD,  2);
      add(0, OP_LD,  0, 0, O_WBM,  2);   add(0, OP_ST,  0, 1, O_FRDY, 3);
      add(0, OP_ST,  0, 1, O_DEC,  3);   add(0, OP_ST,  0, 1, O_ADDR, 3);
      add(0, OP_ST,  0, 1, O_MWR,  3);   add(0, OP_BR,  1, 1, O_FRDY, 4);
      add(0, OP_BR,  1, 1, O_DEC,  4);   add(0, OP_BR,  1, 1, O_BR,   4);
      add(0, OP_BR,  0, 1, O_FRDY, 5);   add(0, OP_BR,  0, 1, O_DEC,  5);
      add(0, OP_BR,  0, 1, O_BR,   5);   add(0, 7'h7f,  0, 1, O_FRDY, 6);
      add(0, 7'h7f,  0, 1, O_DECIL, 6);  add(0, OP_JAL, 0, 1, O_FRDY, 6);
      add(0, OP_JAL, 0, 1, O_DEC,  6);   add(0, OP_JAL, 0, 1, O_JAL,  6);
      add(0, OP_LD,  0, 0, O_FWAIT, 7);

      foreach (vt[i]) begin
         rst = vt[i].rst; opcode = vt[i].op; zero_taken = vt[i].zt; mem_ready = vt[i].mr;
         @(negedge clk);
         check($sformatf("vec%0d_out", i), 64'(out_vec), 64'(vt[i].exp_out));
         check($sformatf("vec%0d_retired", i), 64'(retired), 64'(vt[i].exp_ret));
         @(posedge clk); #1;
      end

      // Reset in the middle of a stalled load read.
      mem_ready = 1'b1;
      @(posedge clk); #1;
      mem_ready = 1'b0;
      repeat (2) begin @(posedge clk); #1; end
      @(negedge clk);
      check("rd_pending", 64'({mem_read, iord}), 64'(2'b11));
      #1 rst = 1'b1;
      #1;
      check("rst_async_out", 64'(out_vec), 64'(O_ZERO));
      check("rst_retired", 64'(retired), 64'd0);
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      check("post_rst_idle", 64'(out_vec), 64'(O_ZERO));
      @(posedge clk); #1;
      @(negedge clk);
      check("post_rst_fetch", 64'(out_vec), 64'(O_FWAIT));

      // Random instruction stream, checked per instruction against totals derived
      // from the cycle budget of each instruction class.
      @(posedge clk); #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      @(posedge clk); #1;
      exp_ret = '0;
      for (int n = 0; n < 60; n++) begin
         k  = $urandom_range(0, 6);
         wf = $urandom_range(0, 2);
         wm = $urandom_range(0, 2);
         case (k)
            0: op = OP_R;
            1: op = OP_I;
            2: op = OP_LD;
            3: op = OP_ST;
            4: op = OP_BR;
            5: op = OP_JAL;
            default: begin
               op = 7'($urandom);
               while (is_legal(op)) op = 7'($urandom);
            end
         endcase
         // Fetch waits, then non-memory cycles get random (ignored) mem_ready.
         rq.delete();
         repeat (wf) rq.push_back(1'b0);
         rq.push_back(1'b1);
         case (k)
            0, 1: repeat (3) rq.push_back(1'($urandom));
            2: begin
               repeat (2) rq.push_back(1'($urandom));
               repeat (wm) rq.push_back(1'b0);
               rq.push_back(1'b1);
               rq.push_back(1'($urandom));
            end
            3: begin
               repeat (2) rq.push_back(1'($urandom));
               repeat (wm) rq.push_back(1'b0);
               rq.push_back(1'b1);
            end
            4, 5: repeat (2) rq.push_back(1'($urandom));
            default: rq.push_back(1'($urandom));
         endcase

         e_rd   = wf + 1 + ((k == 2) ? wm + 1 : 0);
         e_wr   = (k == 3) ? wm + 1 : 0;
         e_rw   = (k inside {0, 1, 2, 5}) ? 1 : 0;
         e_pcw  = (k == 5) ? 2 : 1;
         e_pcwc = (k == 4) ? 1 : 0;
         e_irw  = 1;
         e_ill  = (k == 6) ? 1 : 0;
         c_rd = 0; c_wr = 0; c_rw = 0; c_pcw = 0; c_pcwc = 0; c_irw = 0; c_ill = 0;

         opcode = op;
         foreach (rq[i]) begin
            mem_ready  = rq[i];
            zero_taken = 1'($urandom);
            @(negedge clk);
            if (i == 0)
               check($sformatf("ins%0d_fetch_start", n), 64'({mem_read, iord, alu_src_a}),
                     64'(4'b1010));
            check("exclusive_enables", 64'({mem_read & mem_write, pc_write & pc_write_cond}),
                  64'd0);
            c_rd += int'(mem_read);   c_wr += int'(mem_write);   c_rw += int'(reg_write);
            c_pcw += int'(pc_write);  c_pcwc += int'(pc_write_cond);
            c_irw += int'(ir_write);  c_ill += int'(illegal);
            @(posedge clk); #1;
         end
         if (k != 6) exp_ret = exp_ret + 32'd1;
         check($sformatf("ins%0d_retired", n), 64'(retired), 64'(exp_ret));
         check($sformatf("ins%0d_retired_wrap", n), 64'(n_retired), 64'(exp_ret[1:0]));
         check($sformatf("ins%0d_k%0d_counts", n, k),
               {8'(c_rd), 8'(c_wr), 8'(c_rw), 8'(c_pcw), 8'(c_pcwc), 8'(c_irw), 8'(c_ill), 8'd0},
               {8'(e_rd), 8'(e_wr), 8'(e_rw), 8'(e_pcw), 8'(e_pcwc), 8'(e_irw), 8'(e_ill), 8'd0});
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
